// File: rtl/mat_stream_out.sv
// mat_stream_out
// Captures one full-precision product matrix in a single handshake and
// streams it out row-major, one element per beat, over valid/ready.
// Each element is requantised with an arithmetic right shift followed by
// signed saturation to the narrower downstream width.
module mat_stream_out #(
    parameter int SIZE_A     = 8,
    parameter int SIZE_C     = 8,
    parameter int N_BITS_IN  = 67,
    parameter int N_BITS_OUT = 32,
    parameter int SHIFT      = 16,
    localparam int ROW_W     = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
    localparam int COL_W     = (SIZE_C > 1) ? $clog2(SIZE_C) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic signed [N_BITS_IN-1:0]  mat_in [SIZE_A][SIZE_C],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [N_BITS_OUT-1:0] out_data,
    output logic        [ROW_W-1:0]      out_row,
    output logic        [COL_W-1:0]      out_col,
    output logic                         out_last,
    output logic                         sat_flag
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Indices of the final element; the beat at this position ends the matrix.
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SIZE_A - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE_C - 1);

    // Saturation bounds expressed at the input width so the shifted value
    // can be compared directly without a further extension step.
    localparam logic signed [N_BITS_IN-1:0] MAX_V =
        {{(N_BITS_IN - N_BITS_OUT + 1){1'b0}}, {(N_BITS_OUT - 1){1'b1}}};
    localparam logic signed [N_BITS_IN-1:0] MIN_V =
        {{(N_BITS_IN - N_BITS_OUT + 1){1'b1}}, {(N_BITS_OUT - 1){1'b0}}};

    // The same bounds at the output width, used when clamping.
    localparam logic signed [N_BITS_OUT-1:0] OUT_MAX = {1'b0, {(N_BITS_OUT - 1){1'b1}}};
    localparam logic signed [N_BITS_OUT-1:0] OUT_MIN = {1'b1, {(N_BITS_OUT - 1){1'b0}}};

    state_t                        state;
    logic signed [N_BITS_IN-1:0]   mat_buf [SIZE_A][SIZE_C];
    logic signed [N_BITS_IN-1:0]   cur_elem;
    logic signed [N_BITS_IN-1:0]   shifted;
    logic                          over_max;
    logic                          under_min;
    logic                          sat_hit;
    logic                          at_last;
    logic                          beat_xfer;

    assign at_last   = (out_row == ROW_LAST) && (out_col == COL_LAST);
    assign out_last  = out_valid && at_last;
    assign beat_xfer = out_valid && out_ready;

    // Requantise the element addressed by the current indices: floor shift,
    // then clamp to the output range; out_data is forced to zero while idle.
    always_comb begin
        cur_elem  = mat_buf[out_row][out_col];
        shifted   = cur_elem >>> SHIFT;
        over_max  = shifted > MAX_V;
        under_min = shifted < MIN_V;
        sat_hit   = out_valid && (over_max || under_min);
        out_data  = '0;
        if (out_valid) begin
            if (over_max) begin
                out_data = OUT_MAX;
            end else if (under_min) begin
                out_data = OUT_MIN;
            end else begin
                out_data = shifted[N_BITS_OUT-1:0];
            end
        end
    end

    // Control FSM: capture a matrix in IDLE, walk the indices row-major in
    // STREAM, and drop back to IDLE once the last element has transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            sat_flag   <= 1'b0;
            for (int r = 0; r < SIZE_A; r++) begin
                for (int c = 0; c < SIZE_C; c++) begin
                    mat_buf[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        mat_buf    <= mat_in;
                        out_row    <= '0;
                        out_col    <= '0;
                        sat_flag   <= 1'b0;
                        load_ready <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_xfer) begin
                        if (sat_hit) begin
                            sat_flag <= 1'b1;
                        end
                        if (at_last) begin
                            out_row    <= '0;
                            out_col    <= '0;
                            out_valid  <= 1'b0;
                            load_ready <= 1'b1;
                            state      <= IDLE;
                        end else if (out_col == COL_LAST) begin
                            out_col <= '0;
                            out_row <= out_row + ROW_W'(1);
                        end else begin
                            out_col <= out_col + COL_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
